// File: rtl/avl_traffic_gen_master.sv
// Avalon-style traffic generator master.
// Issues a reproducible pseudo-random stream of word-aligned reads and writes
// inside one address window, limits reads in flight, counts responses and
// reports completion. Command fields come from a 32-bit Galois LFSR that is
// stepped once per GEN cycle and once per accepted command.
module avl_traffic_gen_master #(
  parameter int unsigned MASTER_ID         = 0,
  parameter logic [31:0] ADDR_BASE         = 32'h0000_0000,
  parameter int unsigned ADDR_SPAN_LOG2    = 10,
  parameter int unsigned NUM_CMDS          = 256,
  parameter int unsigned MAX_OUTSTANDING   = 4,
  parameter logic [31:0] SEED              = 32'hACE1_2468,
  parameter int unsigned WRITE_PCT_LOG2    = 1,
  parameter bit          RESP_BACKPRESSURE = 1'b0
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        start,
  output logic [31:0] address,
  output logic [3:0]  byte_en,
  output logic        read,
  output logic        write,
  output logic [31:0] write_data,
  input  logic        request_ready,
  input  logic [31:0] read_data,
  input  logic        read_data_valid,
  output logic        resp_ready,
  output logic        busy,
  output logic        done,
  output logic        resp_err,
  output logic [15:0] cmd_count,
  output logic [15:0] rd_count
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED_MIX  = SEED ^ 32'(MASTER_ID);
  // An all-zero Galois LFSR never leaves zero, so that seed is replaced.
  localparam logic [31:0] SEED_INIT = (SEED_MIX == 32'd0) ? 32'd1 : SEED_MIX;
  // Keeps the in-window word offset bits [ADDR_SPAN_LOG2-1:2].
  localparam logic [31:0] OFFS_MASK = ((32'd1 << ADDR_SPAN_LOG2) - 32'd1) & 32'hFFFF_FFFC;
  // Zero mask (WRITE_PCT_LOG2 == 0) makes every command a write.
  localparam logic [31:0] WR_MASK   = (32'd1 << WRITE_PCT_LOG2) - 32'd1;
  localparam logic [3:0]  MAX_OUT   = 4'(MAX_OUTSTANDING);
  localparam logic [16:0] LAST_CMD  = 17'(NUM_CMDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] lfsr_reg;
  logic [31:0] lfsr_step;
  logic [31:0] addr_reg;
  logic [3:0]  byte_en_reg;
  logic [31:0] wdata_reg;
  logic        is_write_reg;
  logic [3:0]  outstanding_reg;
  logic [15:0] cmd_count_reg;
  logic [15:0] rd_count_reg;
  logic        resp_err_reg;

  logic        cmd_read;
  logic        cmd_write;
  logic        cmd_accept;
  logic        read_accept;
  logic        resp_hs;
  logic        start_run;
  logic        last_cmd;
  logic        resp_level;

  // Read data is checked downstream by the bus monitor, not here.
  logic unused_read_data;
  assign unused_read_data = ^read_data;

  // One Galois step (right shift, feedback from bit 0).
  always_comb begin
    lfsr_step = {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 32'h0);
  end

  // A read is held off while the in-flight limit is reached; writes never are.
  assign cmd_write   = (state_reg == ST_ISSUE) && is_write_reg;
  assign cmd_read    = (state_reg == ST_ISSUE) && !is_write_reg && (outstanding_reg != MAX_OUT);
  assign cmd_accept  = (cmd_read || cmd_write) && request_ready;
  assign read_accept = cmd_read && request_ready;
  assign resp_hs     = read_data_valid && resp_ready;
  assign start_run   = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign last_cmd    = (({1'b0, cmd_count_reg}) + 17'd1) == LAST_CMD;
  assign resp_level  = RESP_BACKPRESSURE ? lfsr_reg[31] : 1'b1;

  assign read       = cmd_read;
  assign write      = cmd_write;
  assign address    = addr_reg;
  assign byte_en    = byte_en_reg;
  assign write_data = wdata_reg;
  assign resp_err   = resp_err_reg;
  assign cmd_count  = cmd_count_reg;
  assign rd_count   = rd_count_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rest) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    resp_ready = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_GEN;
      end
      ST_GEN: begin
        busy       = 1'b1;
        resp_ready = resp_level;
        state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy       = 1'b1;
        resp_ready = resp_level;
        if (cmd_accept) state_next = last_cmd ? ST_DRAIN : ST_GEN;
      end
      ST_DRAIN: begin
        busy       = 1'b1;
        resp_ready = resp_level;
        if (outstanding_reg == 4'd0) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        resp_ready = resp_level;
        if (start) state_next = ST_GEN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // LFSR: steps on GEN and on every accepted command, nowhere else.
  always_ff @(posedge clk) begin
    if (rest) begin
      lfsr_reg <= SEED_INIT;
    end else if ((state_reg == ST_GEN) || cmd_accept) begin
      lfsr_reg <= lfsr_step;
    end
  end

  // Command latch: fields are taken from the freshly stepped LFSR in GEN and
  // stay frozen until the next GEN, so they are stable while driven.
  always_ff @(posedge clk) begin
    if (rest) begin
      addr_reg     <= 32'h0;
      byte_en_reg  <= 4'h0;
      wdata_reg    <= 32'h0;
      is_write_reg <= 1'b0;
    end else if (state_reg == ST_GEN) begin
      addr_reg     <= ADDR_BASE + (lfsr_step & OFFS_MASK);
      is_write_reg <= (lfsr_step & WR_MASK) == 32'h0;
      if ((lfsr_step & WR_MASK) == 32'h0) begin
        byte_en_reg <= (lfsr_step[27:24] == 4'h0) ? 4'hF : lfsr_step[27:24];
        wdata_reg   <= lfsr_step;
      end else begin
        byte_en_reg <= 4'hF;
        wdata_reg   <= 32'h0;
      end
    end
  end

  // Reads in flight; a simultaneous issue and response cancel out, and a
  // stray response never underflows the counter.
  always_ff @(posedge clk) begin
    if (rest) begin
      outstanding_reg <= 4'd0;
    end else begin
      case ({read_accept, resp_hs})
        2'b10:   outstanding_reg <= outstanding_reg + 4'd1;
        2'b01:   if (outstanding_reg != 4'd0) outstanding_reg <= outstanding_reg - 4'd1;
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

  // Run statistics and the sticky unexpected-response flag, cleared per run.
  always_ff @(posedge clk) begin
    if (rest || start_run) begin
      cmd_count_reg <= 16'd0;
      rd_count_reg  <= 16'd0;
      resp_err_reg  <= 1'b0;
    end else begin
      if (cmd_accept) cmd_count_reg <= cmd_count_reg + 16'd1;
      if (resp_hs) rd_count_reg <= rd_count_reg + 16'd1;
      if (resp_hs && (outstanding_reg == 4'd0)) resp_err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avl_traffic_gen_master.sv
// Self-checking bench for avl_traffic_gen_master.
// Instance A: 8 commands, writes only. Instance B: 256 commands, reads only,
// at most 2 reads in flight, window base near the top of the address space.
// Expected commands come from a bench-side LFSR model and are queued when a
// run is started; they are popped and compared as the DUT presents them.
module tb_avl_traffic_gen_master;

  localparam logic [31:0] A_BASE = 32'h1000_0000;
  localparam logic [31:0] B_BASE = 32'hFFFF_FF00;
  localparam logic [31:0] SEED_V = 32'hACE1_2468;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_rest, a_start, a_rr, a_rdv;
  logic [31:0] a_address, a_write_data;
  logic [3:0]  a_byte_en;
  logic        a_read, a_write, a_resp_ready, a_busy, a_done, a_resp_err;
  logic [15:0] a_cmd_count, a_rd_count;
  // Instance B signals
  logic        b_rest, b_start, b_rr, b_rdv;
  logic [31:0] b_address, b_write_data;
  logic [3:0]  b_byte_en;
  logic        b_read, b_write, b_resp_ready, b_busy, b_done, b_resp_err;
  logic [15:0] b_cmd_count, b_rd_count;

  avl_traffic_gen_master #(
    .MASTER_ID(1), .ADDR_BASE(A_BASE), .ADDR_SPAN_LOG2(10), .NUM_CMDS(8),
    .MAX_OUTSTANDING(4), .SEED(SEED_V), .WRITE_PCT_LOG2(0), .RESP_BACKPRESSURE(1'b0)
  ) u_a (
    .clk(clk), .rest(a_rest), .start(a_start),
    .address(a_address), .byte_en(a_byte_en), .read(a_read), .write(a_write),
    .write_data(a_write_data), .request_ready(a_rr), .read_data(32'h0),
    .read_data_valid(a_rdv), .resp_ready(a_resp_ready), .busy(a_busy), .done(a_done),
    .resp_err(a_resp_err), .cmd_count(a_cmd_count), .rd_count(a_rd_count)
  );

  avl_traffic_gen_master #(
    .MASTER_ID(2), .ADDR_BASE(B_BASE), .ADDR_SPAN_LOG2(10), .NUM_CMDS(256),
    .MAX_OUTSTANDING(2), .SEED(SEED_V), .WRITE_PCT_LOG2(31), .RESP_BACKPRESSURE(1'b0)
  ) u_b (
    .clk(clk), .rest(b_rest), .start(b_start),
    .address(b_address), .byte_en(b_byte_en), .read(b_read), .write(b_write),
    .write_data(b_write_data), .request_ready(b_rr), .read_data(32'h1234_5678),
    .read_data_valid(b_rdv), .resp_ready(b_resp_ready), .busy(b_busy), .done(b_done),
    .resp_err(b_resp_err), .cmd_count(b_cmd_count), .rd_count(b_rd_count)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  cmd_t q_a[$];
  cmd_t q_b[$];
  logic [31:0] m_a, m_b;

  function automatic logic [31:0] lfsr_adv(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic cmd_t make_cmd(input logic [31:0] l, input logic [31:0] base,
                                    input int span_log2, input int wpl);
    cmd_t c;
    logic [31:0] mask;
    mask = 32'h0;
    for (int i = 2; i < span_log2; i++) mask[i] = 1'b1;
    c.addr = base + (l & mask);
    c.wr = 1'b1;
    for (int i = 0; i < wpl; i++) if (l[i]) c.wr = 1'b0;
    if (c.wr) begin
      c.be   = (l[27:24] == 4'h0) ? 4'hF : l[27:24];
      c.data = l;
    end else begin
      c.be   = 4'hF;
      c.data = 32'h0;
    end
    return c;
  endfunction

  // Queue the next n commands of a run (GEN step, then accept step each).
  task automatic fill_a(input int n);
    for (int k = 0; k < n; k++) begin
      m_a = lfsr_adv(m_a);
      q_a.push_back(make_cmd(m_a, A_BASE, 10, 0));
      m_a = lfsr_adv(m_a);
    end
  endtask

  task automatic fill_b(input int n);
    for (int k = 0; k < n; k++) begin
      m_b = lfsr_adv(m_b);
      q_b.push_back(make_cmd(m_b, B_BASE, 10, 31));
      m_b = lfsr_adv(m_b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consume n write commands on A with request_ready high.
  task automatic consume_a(input int n, input bit chk_spacing);
    int got, cyc, last_cyc;
    cmd_t e;
    got = 0; cyc = 0; last_cyc = 0;
    while (got < n && cyc < 200) begin
      if (a_write && a_rr) begin
        e = q_a.pop_front();
        $display("A write %0d addr=%h be=%h data=%h", got, a_address, a_byte_en, a_write_data);
        n_checks++;
        if ({a_write, a_read, a_address, a_byte_en, a_write_data} !== {1'b1, 1'b0, e.addr, e.be, e.data}) begin
          n_fail++;
          $display("FAIL a_cmd_fields: got wr=%b rd=%b addr=%h be=%h data=%h expected wr=1 rd=0 addr=%h be=%h data=%h",
                   a_write, a_read, a_address, a_byte_en, a_write_data, e.addr, e.be, e.data);
        end
        n_checks++;
        if (a_address < A_BASE || a_address > A_BASE + 32'd1020 || a_address[1:0] != 2'b00) begin
          n_fail++;
          $display("FAIL a_addr_window: got %h expected aligned in [%h,%h]", a_address, A_BASE, A_BASE + 32'd1020);
        end
        if (chk_spacing && got > 0) begin
          n_checks++;
          if (cyc - last_cyc != 2) begin
            n_fail++;
            $display("FAIL a_spacing: got %0d cycles expected 2", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (got != n) begin
      n_fail++;
      $display("FAIL a_consume_timeout: got %0d commands expected %0d", got, n);
    end
  endtask

  task automatic test_reset();
    a_rest = 1'b1; b_rest = 1'b1;
    tick(); tick();
    a_rest = 1'b0; b_rest = 1'b0;
    n_checks++;
    if ({a_read, a_write, a_busy, a_done, a_resp_err, a_resp_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_a_ctrl: got rd=%b wr=%b busy=%b done=%b err=%b rr=%b expected all 0",
               a_read, a_write, a_busy, a_done, a_resp_err, a_resp_ready);
    end
    n_checks++;
    if ({a_address, a_byte_en, a_write_data, a_cmd_count, a_rd_count} !== 100'h0) begin
      n_fail++;
      $display("FAIL reset_a_data: got addr=%h be=%h data=%h cmd=%0d rd=%0d expected 0",
               a_address, a_byte_en, a_write_data, a_cmd_count, a_rd_count);
    end
    n_checks++;
    if ({b_read, b_write, b_busy, b_done, b_resp_err, b_resp_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_b_ctrl: got rd=%b wr=%b busy=%b done=%b err=%b rr=%b expected all 0",
               b_read, b_write, b_busy, b_done, b_resp_err, b_resp_ready);
    end
    n_checks++;
    if ({b_address, b_byte_en, b_write_data, b_cmd_count, b_rd_count} !== 100'h0) begin
      n_fail++;
      $display("FAIL reset_b_data: got addr=%h be=%h data=%h cmd=%0d rd=%0d expected 0",
               b_address, b_byte_en, b_write_data, b_cmd_count, b_rd_count);
    end
  endtask

  task automatic test_write_stream();
    int w;
    fill_a(8);
    a_rr = 1'b1;
    a_start = 1'b1; tick(); a_start = 1'b0;
    consume_a(8, 1'b1);
    w = 0;
    while (!a_done && w < 5) begin tick(); w++; end
    n_checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_cmd_count !== 16'd8) begin
      n_fail++;
      $display("FAIL write_stream_done: got done=%b busy=%b cmd=%0d expected done=1 busy=0 cmd=8",
               a_done, a_busy, a_cmd_count);
    end
  endtask

  task automatic test_stall();
    int w;
    cmd_t e;
    fill_a(8);
    a_rr = 1'b0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    n_checks++;
    if (a_cmd_count !== 16'd0 || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_restart: got cmd=%0d busy=%b expected cmd=0 busy=1", a_cmd_count, a_busy);
    end
    w = 0;
    while (!a_write && w < 10) begin tick(); w++; end
    e = q_a.pop_front();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) a_rr = 1'b1;
      n_checks++;
      if ({a_write, a_address, a_byte_en, a_write_data, a_cmd_count} !== {1'b1, e.addr, e.be, e.data, 16'd0}) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got wr=%b addr=%h be=%h data=%h cmd=%0d expected wr=1 addr=%h be=%h data=%h cmd=0",
                 i, a_write, a_address, a_byte_en, a_write_data, a_cmd_count, e.addr, e.be, e.data);
      end
      tick();
    end
    $display("A stalled write accepted addr=%h", e.addr);
    n_checks++;
    if (a_cmd_count !== 16'd1 || a_write !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_accept: got cmd=%0d wr=%b expected cmd=1 wr=0", a_cmd_count, a_write);
    end
    consume_a(7, 1'b1);
    w = 0;
    while (!a_done && w < 5) begin tick(); w++; end
    n_checks++;
    if (a_done !== 1'b1 || a_cmd_count !== 16'd8) begin
      n_fail++;
      $display("FAIL stall_done: got done=%b cmd=%0d expected done=1 cmd=8", a_done, a_cmd_count);
    end
  endtask

  task automatic test_resp_err();
    n_checks++;
    if (a_resp_err !== 1'b0 || a_resp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_err_pre: got err=%b rr=%b expected err=0 rr=1", a_resp_err, a_resp_ready);
    end
    a_rdv = 1'b1; tick(); a_rdv = 1'b0;
    $display("A stray response in DONE");
    n_checks++;
    if (a_resp_err !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_err_set: got %b expected 1", a_resp_err);
    end
    tick(); tick(); tick();
    n_checks++;
    if (a_resp_err !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_err_sticky: got %b expected 1", a_resp_err);
    end
    a_start = 1'b1; tick(); a_start = 1'b0;
    n_checks++;
    if (a_resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_err_clear: got %b expected 0", a_resp_err);
    end
    a_rest = 1'b1; tick(); a_rest = 1'b0;
  endtask

  task automatic test_outstanding_limit();
    int got, w;
    cmd_t e;
    fill_b(8);
    b_rr = 1'b1; b_rdv = 1'b0;
    b_start = 1'b1; tick(); b_start = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (b_read && b_rr) begin
        e = q_b.pop_front();
        $display("B read %0d addr=%h", got, b_address);
        n_checks++;
        if ({b_write, b_read, b_address, b_byte_en, b_write_data} !== {e.wr, ~e.wr, e.addr, e.be, e.data}) begin
          n_fail++;
          $display("FAIL b_cmd_fields: got wr=%b rd=%b addr=%h be=%h data=%h expected wr=%b addr=%h be=%h data=%h",
                   b_write, b_read, b_address, b_byte_en, b_write_data, e.wr, e.addr, e.be, e.data);
        end
        got++;
      end
      tick();
    end
    n_checks++;
    if (got != 2 || b_read !== 1'b0 || b_busy !== 1'b1 || b_rd_count !== 16'd0) begin
      n_fail++;
      $display("FAIL outstanding_cap: got reads=%0d rd=%b busy=%b rdcnt=%0d expected reads=2 rd=0 busy=1 rdcnt=0",
               got, b_read, b_busy, b_rd_count);
    end
    b_rdv = 1'b1; tick(); b_rdv = 1'b0;
    n_checks++;
    if (b_rd_count !== 16'd1) begin
      n_fail++;
      $display("FAIL outstanding_resp: got rdcnt=%0d expected 1", b_rd_count);
    end
    w = 0;
    while (!(b_read && b_rr) && w < 5) begin tick(); w++; end
    n_checks++;
    if (b_read !== 1'b1) begin
      n_fail++;
      $display("FAIL outstanding_third: got rd=%b expected 1 after response", b_read);
    end else begin
      e = q_b.pop_front();
      $display("B read 2 addr=%h", b_address);
      n_checks++;
      if (b_address !== e.addr) begin
        n_fail++;
        $display("FAIL b_third_addr: got %h expected %h", b_address, e.addr);
      end
    end
    tick();
  endtask

  task automatic test_same_cycle();
    cmd_t e;
    tick();
    n_checks++;
    if (b_read !== 1'b0 || b_cmd_count !== 16'd3) begin
      n_fail++;
      $display("FAIL same_pre: got rd=%b cmd=%0d expected rd=0 cmd=3", b_read, b_cmd_count);
    end
    b_rr = 1'b0; b_rdv = 1'b1; tick(); b_rdv = 1'b0;
    n_checks++;
    if (b_read !== 1'b1 || b_rd_count !== 16'd2) begin
      n_fail++;
      $display("FAIL same_release: got rd=%b rdcnt=%0d expected rd=1 rdcnt=2", b_read, b_rd_count);
    end
    e = q_b.pop_front();
    n_checks++;
    if (b_address !== e.addr) begin
      n_fail++;
      $display("FAIL same_addr: got %h expected %h", b_address, e.addr);
    end
    b_rr = 1'b1; b_rdv = 1'b1; tick(); b_rdv = 1'b0;
    $display("B read 3 addr=%h with simultaneous response", e.addr);
    n_checks++;
    if (b_rd_count !== 16'd3 || b_cmd_count !== 16'd4) begin
      n_fail++;
      $display("FAIL same_counts: got rdcnt=%0d cmd=%0d expected rdcnt=3 cmd=4", b_rd_count, b_cmd_count);
    end
    tick();
    e = q_b.pop_front();
    n_checks++;
    if (b_read !== 1'b1 || b_address !== e.addr) begin
      n_fail++;
      $display("FAIL same_next_read: got rd=%b addr=%h expected rd=1 addr=%h", b_read, b_address, e.addr);
    end
    $display("B read 4 addr=%h", b_address);
    tick(); tick(); tick(); tick();
    n_checks++;
    if (b_read !== 1'b0 || b_cmd_count !== 16'd5) begin
      n_fail++;
      $display("FAIL same_cap_again: got rd=%b cmd=%0d expected rd=0 cmd=5", b_read, b_cmd_count);
    end
  endtask

  task automatic test_reset_midrun();
    int got, cyc;
    bit resp_due;
    cmd_t e;
    b_rest = 1'b1; tick(); b_rest = 1'b0;
    n_checks++;
    if ({b_read, b_write, b_busy, b_done, b_resp_ready, b_cmd_count, b_rd_count} !== 37'h0) begin
      n_fail++;
      $display("FAIL midrun_reset: got rd=%b wr=%b busy=%b done=%b rr=%b cmd=%0d rdcnt=%0d expected all 0",
               b_read, b_write, b_busy, b_done, b_resp_ready, b_cmd_count, b_rd_count);
    end
    m_b = SEED_V ^ 32'd2;
    q_b.delete();
    fill_b(8);
    b_start = 1'b1; tick(); b_start = 1'b0;
    got = 0; cyc = 0; resp_due = 1'b0;
    while (got < 4 && cyc < 60) begin
      b_rdv = resp_due;
      resp_due = 1'b0;
      if (b_read && b_rr) begin
        e = q_b.pop_front();
        $display("B rerun read %0d addr=%h", got, b_address);
        n_checks++;
        if (b_address !== e.addr) begin
          n_fail++;
          $display("FAIL rerun_addr_%0d: got %h expected %h", got, b_address, e.addr);
        end
        resp_due = 1'b1;
        got++;
      end
      tick();
      cyc++;
    end
    b_rdv = resp_due; tick(); b_rdv = 1'b0;
    n_checks++;
    if (got != 4 || b_rd_count !== 16'd4 || b_cmd_count !== 16'd4 || b_resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rerun_counts: got reads=%0d rdcnt=%0d cmd=%0d err=%b expected 4 4 4 0",
               got, b_rd_count, b_cmd_count, b_resp_err);
    end
  endtask

  initial begin
    a_rest = 1'b0; a_start = 1'b0; a_rr = 1'b0; a_rdv = 1'b0;
    b_rest = 1'b0; b_start = 1'b0; b_rr = 1'b0; b_rdv = 1'b0;
    m_a = SEED_V ^ 32'd1;
    m_b = SEED_V ^ 32'd2;
    test_reset();
    test_write_stream();
    test_stall();
    test_resp_err();
    test_outstanding_limit();
    test_same_cycle();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avl_traffic_gen_master.md
Name: avl_traffic_gen_master

Overview:
Synthesizable Avalon-style traffic generator that acts as one bus master. It produces a pseudo-random, reproducible stream of word-aligned read and write commands inside one address window. It sits directly upstream of the bus interconnect and the bus monitor model: one instance drives each master port of i_avl_bus. It also counts responses and reports completion, so a bench can run multi-master stress with a scoreboard attached.

Parameters:
MASTER_ID, 0, index of this master; XORed into the seed so instances differ.
ADDR_BASE, 32'h0000_0000, base byte address of the target window.
ADDR_SPAN_LOG2, 10, window size is 2**ADDR_SPAN_LOG2 bytes; range 2..31.
NUM_CMDS, 256, total commands issued per run; range 1..65535.
MAX_OUTSTANDING, 4, maximum reads issued but not yet answered; range 1..15.
SEED, 32'hACE1_2468, LFSR seed; a value of 0 is replaced by 32'h1.
WRITE_PCT_LOG2, 1, a command is a write when lfsr[WRITE_PCT_LOG2-1:0]==0; a value of 0 means writes only.
RESP_BACKPRESSURE, 0, 1 means resp_ready follows LFSR bit 31; 0 means resp_ready is held at 1.

Ports:
clk  input  1  clock; all logic on the rising edge.
rest  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins a run when the block is in IDLE or DONE.
address  output  32  command byte address, word-aligned.
byte_en  output  4  byte enables.
read  output  1  read command valid.
write  output  1  write command valid.
write_data  output  32  write data.
request_ready  input  1  the bus accepts the command this cycle.
read_data  input  32  read response data.
read_data_valid  input  1  read response valid.
resp_ready  output  1  master accepts the response.
busy  output  1  high in GEN, ISSUE and DRAIN.
done  output  1  high in DONE.
resp_err  output  1  sticky; set by a response that arrives while outstanding==0.
cmd_count  output  16  commands accepted so far.
rd_count  output  16  read responses accepted so far.

Behaviour:
- Reset is sampled only at the clk edge. After a reset edge: state=IDLE, read=write=0, address=0, byte_en=0, write_data=0, resp_ready=0, busy=done=resp_err=0, both counters=0, outstanding=0, LFSR=(SEED^MASTER_ID), or 1 if that value is 0.
- A reset in the middle of a run aborts it. read/write are low starting the cycle after the reset edge. Responses still in flight are ignored until the next start.
- LFSR: 32-bit Galois, taps 32'h8020_0003. It advances exactly once per accepted command and once per GEN entry; it never advances otherwise.
- States:
  - IDLE: wait for start; then go to GEN and clear the counters and resp_err.
  - GEN: one cycle; latch the next command from the LFSR, then go to ISSUE.
  - ISSUE: drive read or write. A read is held off (read stays low) while outstanding==MAX_OUTSTANDING. The command is accepted on the first cycle where it is driven and request_ready=1. On acceptance: if cmd_count+1==NUM_CMDS go to DRAIN, otherwise go to GEN.
  - DRAIN: wait for outstanding==0, then go to DONE.
  - DONE: done=1; start returns to GEN.
- Command fields:
  - address = ADDR_BASE + ((lfsr[31:2] masked to ADDR_SPAN_LOG2-2 bits)<<2); the addition wraps modulo 2**32.
  - Writes: byte_en=lfsr[27:24], forced to 4'hF if zero; write_data = LFSR value after the advance.
  - Reads: byte_en=4'hF, write_data=0.
- While a command is driven, address, byte_en, write_data, read and write are held stable until accepted. read and write are never both high.
- Outstanding counter (4 bit): +1 on an accepted read, −1 on a response handshake (read_data_valid && resp_ready). When both happen in the same cycle the counter is unchanged. A handshake with outstanding==0 sets resp_err and leaves the counter at 0.
- resp_ready: 0 in IDLE. In any other state it is 1, or LFSR bit 31 when RESP_BACKPRESSURE=1.
- read_data is not checked here; the bus monitor scoreboard checks it.
- Latency: a command is first driven the cycle after GEN. With request_ready tied to 1, sustained throughput is one command per 2 cycles.

Test Plan:
- Reset, pulse start, request_ready=1, NUM_CMDS=8, WRITE_PCT_LOG2=0 -> 8 writes at 2-cycle spacing; every address in [ADDR_BASE, ADDR_BASE+1020] and ≡0 mod 4; done=1 after the 8th acceptance; cmd_count=8.
- request_ready held at 0 for 5 cycles during ISSUE -> address, byte_en, write_data and write stable across all 5 cycles; accepted on the 6th cycle; cmd_count increments by exactly 1.
- Reads only, MAX_OUTSTANDING=2, read_data_valid held at 0 -> exactly 2 reads accepted, then read stays low; one response pulse -> a third read is issued.
- Accepted read and response handshake in the same cycle with outstanding=1 -> outstanding stays 1; rd_count increments by 1.
- read_data_valid=1 in DONE with outstanding=0 -> resp_err=1 and stays 1 until the next start or reset.
- rest asserted mid-run with NUM_CMDS=256 -> next cycle: read=write=0, IDLE, counters 0; rerun with the same SEED reproduces the first 4 addresses bit-exactly.
